// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, one-outstanding imem read, {inst, pc} handed to decode.
// At least 3 cycles per instruction; holds the request while imem is not ready and the instruction while decode is not ready.
module instruction_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_1000)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_inst_data;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_discard;
  logic            r_req_valid;
  logic            r_inst_valid;
  logic            r_misaligned;

  logic [XLEN-1:0] w_redirect_pc_al;
  logic            w_req_fire;

  assign w_redirect_pc_al = {redirect_pc[XLEN-1:2], 2'b00};
  // r_req_valid is only ever set while in S_REQ, so this is the request handshake.
  assign w_req_fire       = r_req_valid & imem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_inst_data  <= '0;
      r_inst_pc    <= '0;
      r_discard    <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= redirect_valid & (|redirect_pc[1:0]);
      if (redirect_valid) begin
        r_pc <= w_redirect_pc_al;
        case (r_state)
          S_REQ: begin
            if (w_req_fire) begin
              r_req_pc    <= r_pc;
              r_discard   <= 1'b1;
              r_req_valid <= 1'b0;
              r_state     <= S_WAIT;
            end else begin
              r_req_valid <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              r_discard   <= 1'b0;
              r_req_valid <= 1'b1;
              r_state     <= S_REQ;
            end else begin
              r_discard   <= 1'b1;
            end
          end
          S_HOLD: begin
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
            r_state      <= S_REQ;
          end
          default: begin
            r_req_valid <= 1'b1;
            r_state     <= S_REQ;
          end
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            if (w_req_fire) begin
              r_req_pc    <= r_pc;
              r_req_valid <= 1'b0;
              r_state     <= S_WAIT;
            end else begin
              r_req_valid <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              if (r_discard) begin
                r_discard   <= 1'b0;
                r_req_valid <= 1'b1;
                r_state     <= S_REQ;
              end else begin
                r_inst_data  <= imem_rsp_data;
                r_inst_pc    <= r_req_pc;
                r_inst_valid <= 1'b1;
                r_pc         <= r_req_pc + XLEN'(4);
                r_state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (inst_ready) begin
              r_inst_valid <= 1'b0;
              r_req_valid  <= 1'b1;
              r_state      <= S_REQ;
            end
          end
          default: begin
            r_req_valid <= 1'b1;
            r_state     <= S_REQ;
          end
        endcase
      end
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;
  assign misaligned     = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed per-cycle vector table, reset-mid-fetch sequence,
// then randomized traffic against a stream-level model of the expected instruction sequence.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misaligned;

  instruction_fetch #(.XLEN(32), .RESET_PC(32'h0000_1000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .misaligned     (misaligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rv;
    logic [31:0] rpc;
    logic        rr;
    logic        sv;
    logic [31:0] sd;
    logic        ir;
    logic        e_req_v;
    logic [31:0] e_addr;
    logic        e_inst_v;
    logic [31:0] e_inst_pc;
    logic [31:0] e_inst_d;
    logic        e_mis;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rr,
                              input logic sv, input logic [31:0] sd, input logic ir,
                              input logic erv, input logic [31:0] ea, input logic eiv,
                              input logic [31:0] epc, input logic [31:0] ed, input logic em);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rr = rr; v.sv = sv; v.sd = sd; v.ir = ir;
    v.e_req_v = erv; v.e_addr = ea; v.e_inst_v = eiv; v.e_inst_pc = epc; v.e_inst_d = ed; v.e_mis = em;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F69;
  endfunction

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_pc, held_pc, held_data, mem_addr, rpc;
  logic        exp_mis, hold_prev, mem_busy, rv;
  int          mem_cnt, n_del;

  initial begin
    rst_n = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'h1000);

    //          rv rpc           rr sv sd            ir   erv addr          eiv ipc           idata         mis
    vt.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h1000,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h1000,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        0, 1, 32'h00A00093, 0,   0, 32'h1004,     1, 32'h1000,     32'h00A00093, 0));
    vt.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h1004,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h1004,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        0, 1, 32'h00108113, 0,   0, 32'h1008,     1, 32'h1004,     32'h00108113, 0));
    vt.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h1008,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h1008,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 32'h2010,     0, 0, 32'h0,        0,   0, 32'h2010,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        0, 1, 32'hDEADBEEF, 0,   1, 32'h2010,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h2010,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        0, 1, 32'h11111111, 0,   0, 32'h2014,     1, 32'h2010,     32'h11111111, 0));
    for (int k = 0; k < 5; k++)
      vt.push_back(mk(0, 32'h0, 1, (k == 2), 32'hBAD0BAD0, 0, 0, 32'h2014, 1, 32'h2010, 32'h11111111, 0));
    vt.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h2014,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 32'h2012,     0, 0, 32'h0,        0,   1, 32'h2010,     0, 32'h0,        32'h0,        1));
    vt.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h2010,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 32'h0,        0,   1, 32'hFFFFFFFC, 0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0,   0, 32'hFFFFFFFC, 0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        0, 1, 32'hCAFEF00D, 0,   0, 32'h0,        1, 32'hFFFFFFFC, 32'hCAFEF00D, 0));
    vt.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 32'h3000,     1, 0, 32'h0,        0,   0, 32'h3000,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        0, 1, 32'hDEAD0001, 0,   1, 32'h3000,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h3000,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        0, 1, 32'h33333333, 0,   0, 32'h3004,     1, 32'h3000,     32'h33333333, 0));
    vt.push_back(mk(1, 32'h4001,     0, 0, 32'h0,        1,   1, 32'h4000,     0, 32'h0,        32'h0,        1));
    vt.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h4000,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h4000,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 32'h5000,     0, 1, 32'hBADBAD00, 0,   1, 32'h5000,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h5000,     0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 32'h0,        0, 1, 32'h55555555, 0,   0, 32'h5004,     1, 32'h5000,     32'h55555555, 0));
    vt.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h5004,     0, 32'h0,        32'h0,        0));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      redirect_valid = vt[i].rv;
      redirect_pc    = vt[i].rpc;
      imem_req_ready = vt[i].rr;
      imem_rsp_valid = vt[i].sv;
      imem_rsp_data  = vt[i].sd;
      inst_ready     = vt[i].ir;
      @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].e_req_v));
      chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(vt[i].e_inst_v));
      chk($sformatf("vec%0d_misaligned", i), 32'(misaligned), 32'(vt[i].e_mis));
      if (vt[i].e_inst_v) begin
        chk($sformatf("vec%0d_inst_pc", i), inst_pc, vt[i].e_inst_pc);
        chk($sformatf("vec%0d_inst_data", i), inst_data, vt[i].e_inst_d);
      end
    end

    // Reset while a fetch is outstanding, with the stale response arriving around release.
    redirect_valid = 1'b0; inst_ready = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    chk("r7_in_wait", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAADF00D;
    #1;
    chk("r7_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("r7_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("r7_rst_addr", imem_addr, 32'h1000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r7_post_inst_valid", 32'(inst_valid), 32'd0);
    chk("r7_post_req_valid", 32'(imem_req_valid), 32'd1);
    chk("r7_post_addr", imem_addr, 32'h1000);
    @(negedge clk);
    chk("r7_late_inst_valid", 32'(inst_valid), 32'd0);
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("r7_fetch_valid", 32'(inst_valid), 32'd1);
    chk("r7_fetch_pc", inst_pc, 32'h1000);
    chk("r7_fetch_data", inst_data, 32'h12345678);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("r7_next_addr", imem_addr, 32'h1004);

    // Randomized traffic: delivered stream must be consecutive PCs from the last redirect target.
    do_reset();
    exp_pc = 32'h1000; exp_mis = 1'b0; hold_prev = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0; n_del = 0;
    held_pc = '0; held_data = '0;
    for (int c = 0; c < 4000; c++) begin
      chk("rnd_misaligned", 32'(misaligned), 32'(exp_mis));
      if (hold_prev) begin
        chk("rnd_hold_valid", 32'(inst_valid), 32'd1);
        chk("rnd_hold_pc", inst_pc, held_pc);
        chk("rnd_hold_data", inst_data, held_data);
      end
      if (inst_valid) chk("rnd_no_req_in_hold", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid) begin
        chk("rnd_addr_aligned", 32'(imem_addr[1:0]), 32'd0);
        chk("rnd_one_outstanding", 32'(mem_busy), 32'd0);
      end

      rv = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else                        rpc = 32'h0000_8000 + 32'($urandom_range(255));
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_req_ready = ($urandom_range(3) != 0);
      inst_ready     = ($urandom_range(2) != 0);
      if (mem_busy && mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end

      if (inst_valid && inst_ready) begin
        chk("rnd_stream_pc", inst_pc, exp_pc);
        chk("rnd_stream_data", inst_data, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
      if (rv) exp_pc = {rpc[31:2], 2'b00};
      exp_mis   = rv && (rpc[1:0] != 2'b00);
      hold_prev = inst_valid && !inst_ready && !rv;
      held_pc   = inst_pc;
      held_data = inst_data;

      if (imem_rsp_valid) mem_busy = 1'b0;
      else if (mem_busy)  mem_cnt--;
      if (imem_req_valid && imem_req_ready) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = int'($urandom_range(2));
      end
      @(negedge clk);
    end
    chk("rnd_progress", 32'(n_del > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
